// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone definitions for the BRAM slave and its EBR wrapper.
//   WB_DW        data bus width (32)
//   WB_SELW      byte-select width (4)
//   init_state_e post-reset clear engine states (INIT_CLEAR, INIT_READY)
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [0:0] {
        INIT_CLEAR = 1'b0,
        INIT_READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/bram_be32.sv
// bram_be32: single-port 2^AW x 32 block RAM with per-byte write enables
// and a registered read port, shaped to map onto iCE40 EBR.
//   clk    clock
//   rst_n  asynchronous active-low reset (read register only)
//   en     port enable for this cycle
//   we     1 = write, 0 = read
//   addr   word address
//   wdata  write data
//   sel    byte enables, bit n covers wdata[8n+7:8n]
//   rdata  registered read data; holds its value when no read is performed
module bram_be32
    import wb_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [WB_DW-1:0]   wdata,
    input  logic [WB_SELW-1:0] sel,
    output logic [WB_DW-1:0]   rdata
);

    logic [WB_DW-1:0] mem [0:(2**AW)-1];

    // Array kept free of reset so the tools can place it in EBR.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < WB_SELW; b++) begin
                if (sel[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register only loads on reads, so it keeps the last read value
    // across writes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_bram_slave.sv
// wb_bram_slave: pipelined Wishbone B4 slave backed by block RAM.
// One request per clock, acknowledge exactly one cycle after acceptance,
// byte selects honoured on writes.
//
// Optional feature macro: WB_BRAM_INIT_CLEAR_EN
//   defined     -> after reset a clear engine writes zero to every word,
//                  holding o_wb_stall high for 2^AW cycles, then o_init_done=1
//   not defined -> no clear engine; o_wb_stall=0, o_init_done=1 always
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_wb_cyc, i_wb_stb      bus cycle and request strobe
//   i_wb_we                 1 = write, 0 = read
//   i_wb_addr               word address (AW bits)
//   i_wb_data, i_wb_sel     write data and byte enables
//   o_wb_stall              request not accepted this cycle
//   o_wb_ack                one-cycle acknowledge per accepted request
//   o_wb_data               read data, valid with o_wb_ack
//   o_init_done             array ready for bus traffic
//
// Handshake: a request is taken on a rising edge when cyc && stb && !stall;
// its ack is high for the following cycle only, and is dropped if cyc is
// low in that cycle (the master abandoned the cycle).
module wb_bram_slave
    import wb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = WB_DW
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [AW-1:0]      i_wb_addr,
    input  logic [DW-1:0]      i_wb_data,
    input  logic [WB_SELW-1:0] i_wb_sel,
    output logic               o_wb_stall,
    output logic               o_wb_ack,
    output logic [DW-1:0]      o_wb_data,
    output logic               o_init_done
);

    logic          accept;
    logic          ack_q;
    logic          clear_active;
    logic [AW-1:0] clr_cnt;

    logic               ram_en;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [WB_SELW-1:0] ram_sel;

`ifdef WB_BRAM_INIT_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = INIT_CLEAR;
    localparam logic [0:0] ST_READY = INIT_READY;

    logic [0:0] state;

    // Clear engine: one zero word per cycle; the all-ones address is the
    // last word, so the move to READY happens on the same edge that writes it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == {AW{1'b1}}) begin
                state <= ST_READY;
            end
        end
    end

    assign clear_active = (state == ST_CLEAR);
    assign o_wb_stall   = clear_active;
    assign o_init_done  = (state == ST_READY);
`else
    assign clr_cnt      = '0;
    assign clear_active = 1'b0;
    assign o_wb_stall   = 1'b0;
    assign o_init_done  = 1'b1;
`endif

    assign accept = i_wb_cyc && i_wb_stb && !o_wb_stall;

    // Clear engine owns the RAM port while it runs; the bus is stalled then.
    assign ram_en    = clear_active || accept;
    assign ram_we    = clear_active || i_wb_we;
    assign ram_addr  = clear_active ? clr_cnt : i_wb_addr;
    assign ram_wdata = clear_active ? '0 : i_wb_data;
    assign ram_sel   = clear_active ? {WB_SELW{1'b1}} : i_wb_sel;

    bram_be32 #(
        .AW (AW)
    ) u_ram (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .sel   (ram_sel),
        .rdata (o_wb_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= accept;
        end
    end

    // An ack owed to an abandoned cycle must not reach the master.
    assign o_wb_ack = ack_q && i_wb_cyc;

endmodule
